// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    // out_data layout: {ext, brk, code[7:0]}
    localparam int unsigned CODE_W       = 8;
    localparam int unsigned OUT_W        = 10;
    localparam int unsigned OUT_CODE_LSB = 0;
    localparam int unsigned OUT_BRK_BIT  = 8;
    localparam int unsigned OUT_EXT_BIT  = 9;

endpackage

// File: rtl/ps2_fifo.sv
// Show-ahead FIFO; a push into a full FIFO is accepted only when a pop happens the same cycle.
module ps2_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop_ready,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     push_ok_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, valid_d;
    logic             pop_c;
    logic             do_push_c;

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pop_c     = valid_q & pop_ready;
        push_ok_c = (count_q != CW'(DEPTH)) || pop_c;
        do_push_c = push & push_ok_c;
        if (do_push_c) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push_c) - CW'(pop_c);
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = valid_q;
    assign count    = count_q;

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronise and filter the bus, deframe bytes, decode E0/F0 prefixes, queue events.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT_US = 2000,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned RAW_MODE   = 0
) (
    input  logic                          CLOCK_50,
    input  logic                          RESET_N,
    input  logic                          PS2_CLK,
    input  logic                          PS2_DAT,
    output logic [9:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          clear_ovf
);

    localparam int unsigned FW     = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int unsigned TW     = $clog2(TO_CYC + 1);

    logic clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic filt_q, filt_d, filt_prev_q, filt_prev_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic fall_c;

    ps2_state_e  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_ok_q, par_ok_d;
    logic [TW-1:0] timer_q, timer_d;
    logic        push_q, push_d;
    logic [OUT_W-1:0] push_word_q, push_word_d;
    logic        perr_q, perr_d, ferr_q, ferr_d;
    logic        ext_q, ext_d, brk_q, brk_d;
    logic        ovf_q, ovf_d;
    logic        push_ok_c;

    // Synchronisers and glitch filter: the level flips only after FILTER_LEN differing samples in a row
    always_comb begin
        clk_s1_d    = PS2_CLK;
        clk_s2_d    = clk_s1_q;
        dat_s1_d    = PS2_DAT;
        dat_s2_d    = dat_s1_q;
        filt_d      = filt_q;
        filt_prev_d = filt_q;
        flt_cnt_d   = '0;
        if (clk_s2_q != filt_q) begin
            if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                flt_cnt_d = flt_cnt_q + FW'(1);
            end
        end
    end

    assign fall_c = filt_prev_q & ~filt_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_ok_d    = par_ok_q;
        timer_d     = '0;
        push_d      = 1'b0;
        push_word_d = push_word_q;
        perr_d      = 1'b0;
        ferr_d      = 1'b0;
        ext_d       = ext_q;
        brk_d       = brk_q;

        if (state_q != ST_IDLE && !fall_c) begin
            timer_d = timer_q + TW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (fall_c && !dat_s2_q) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (fall_c) begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall_c) begin
                    par_ok_d = ^{shift_q, dat_s2_q};
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall_c) begin
                    state_d = ST_IDLE;
                    ferr_d  = ~dat_s2_q;
                    perr_d  = ~par_ok_q;
                    if (!dat_s2_q || !par_ok_q) begin
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end else if (RAW_MODE != 0) begin
                        push_d      = 1'b1;
                        push_word_d = OUT_W'(shift_q);
                    end else if (shift_q == PREFIX_EXT) begin
                        ext_d = 1'b1;
                    end else if (shift_q == PREFIX_BRK) begin
                        brk_d = 1'b1;
                    end else begin
                        push_d                                = 1'b1;
                        push_word_d                           = '0;
                        push_word_d[OUT_EXT_BIT]              = ext_q;
                        push_word_d[OUT_BRK_BIT]              = brk_q;
                        push_word_d[OUT_CODE_LSB +: CODE_W]   = shift_q;
                        ext_d                                 = 1'b0;
                        brk_d                                 = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A stalled frame is abandoned and reported as a framing error
        if (state_q != ST_IDLE && !fall_c && timer_q == TW'(TO_CYC - 1)) begin
            state_d = ST_IDLE;
            timer_d = '0;
            ferr_d  = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (clear_ovf) begin
            ovf_d = 1'b0;
        end
        if (push_q && !push_ok_c) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            flt_cnt_q   <= '0;
        end else begin
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            dat_s1_q    <= dat_s1_d;
            dat_s2_q    <= dat_s2_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            flt_cnt_q   <= flt_cnt_d;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_ok_q    <= 1'b0;
            timer_q     <= '0;
            push_q      <= 1'b0;
            push_word_q <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_ok_q    <= par_ok_d;
            timer_q     <= timer_d;
            push_q      <= push_d;
            push_word_q <= push_word_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            ovf_q       <= ovf_d;
        end
    end

    ps2_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLOCK_50),
        .rst_n     (RESET_N),
        .push      (push_q),
        .push_data (push_word_q),
        .pop_ready (out_ready),
        .rd_data   (out_data),
        .rd_valid  (out_valid),
        .count     (fifo_count),
        .push_ok_c (push_ok_c)
    );

    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: PS/2 frames in, decoded events checked against a scoreboard queue.
module tb_ps2_scan_rx;

    localparam int HALF = 20;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b1;
    logic       PS2_CLK  = 1'b1;
    logic       PS2_DAT  = 1'b1;
    logic [9:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] fifo_count;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;
    logic       clear_ovf = 1'b0;

    int checks = 0;
    int errors = 0;
    int perr_seen = 0;
    int ferr_seen = 0;
    logic [9:0] exp_q[$];

    ps2_scan_rx #(
        .CLK_HZ     (1_000_000),
        .FILTER_LEN (8),
        .TIMEOUT_US (2000),
        .FIFO_DEPTH (16),
        .RAW_MODE   (0)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
        .PS2_CLK    (PS2_CLK),
        .PS2_DAT    (PS2_DAT),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .clear_ovf  (clear_ovf)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (RESET_N && parity_err === 1'b1) perr_seen++;
        if (RESET_N && frame_err === 1'b1)  ferr_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // start(0), 8 data bits LSB first, odd parity, stop(1)
    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic flip_par);
        logic p;
        p = ~(^b) ^ flip_par;
        return {1'b1, p, b, 1'b0};
    endfunction

    // Send the first n bits of a frame; a short low glitch can be put ahead of bit glitch_at
    task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_at);
        for (int i = 0; i < n; i++) begin
            PS2_DAT = bits[i];
            if (i == glitch_at) begin
                wait_cyc(3);
                PS2_CLK = 1'b0;
                wait_cyc(3);
                PS2_CLK = 1'b1;
                wait_cyc(HALF / 2 - 6);
            end else begin
                wait_cyc(HALF / 2);
            end
            PS2_CLK = 1'b0;
            wait_cyc(HALF);
            PS2_CLK = 1'b1;
            wait_cyc(HALF / 2);
        end
        PS2_DAT = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par);
        send_bits(mk_frame(b, flip_par), 11, -1);
        wait_cyc(8);
    endtask

    // Pop every expected entry, comparing each head word at its pop
    task automatic drain(input string tag);
        int guard;
        logic [9:0] e;
        guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            @(negedge CLOCK_50);
            guard++;
            if (out_valid === 1'b1) begin
                e = exp_q.pop_front();
                chk({tag, "_pop"}, 32'(out_data), 32'(e));
                out_ready = 1'b1;
                @(posedge CLOCK_50);
                #1 out_ready = 1'b0;
            end
        end
        chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        wait_cyc(2);
        chk({tag, "_cnt0"}, 32'(fifo_count), 32'd0);
    endtask

    initial begin
        int p0;
        int f0;

        // Reset state
        #1 RESET_N = 1'b0;
        #4;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        wait_cyc(3);
        RESET_N = 1'b1;
        wait_cyc(5);

        // Single make code
        send_frame(8'h1C, 1'b0);
        exp_q.push_back(10'h01C);
        chk("f1c_count", 32'(fifo_count), 32'd1);
        chk("f1c_head", 32'(out_data), 32'h01C);
        chk("f1c_perr", 32'(perr_seen), 32'd0);
        chk("f1c_ferr", 32'(ferr_seen), 32'd0);
        drain("f1c");

        // Extended break sequence collapses to one word
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        chk("pfx_count", 32'(fifo_count), 32'd0);
        send_frame(8'h75, 1'b0);
        exp_q.push_back(10'h375);
        chk("ebk_count", 32'(fifo_count), 32'd1);
        drain("ebk");

        // Bad parity: one pulse, no push, next byte clean
        p0 = perr_seen;
        f0 = ferr_seen;
        send_frame(8'h1C, 1'b1);
        chk("par_pulse", 32'(perr_seen - p0), 32'd1);
        chk("par_noframe", 32'(ferr_seen - f0), 32'd0);
        chk("par_count", 32'(fifo_count), 32'd0);
        send_frame(8'h75, 1'b0);
        exp_q.push_back(10'h075);
        drain("par");

        // Overflow: 17 frames into a 16-deep FIFO
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(8'h10 + i), 1'b0);
            if (i < 16) exp_q.push_back(10'(8'h10 + i));
        end
        chk("ovf_count", 32'(fifo_count), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        drain("ovf");
        chk("ovf_sticky", 32'(overflow), 32'd1);
        clear_ovf = 1'b1;
        wait_cyc(1);
        clear_ovf = 1'b0;
        wait_cyc(1);
        chk("ovf_clear", 32'(overflow), 32'd0);

        // Abandoned frame times out
        f0 = ferr_seen;
        send_bits(mk_frame(8'h55, 1'b0), 6, -1);
        wait_cyc(2100);
        chk("to_ferr", 32'(ferr_seen - f0), 32'd1);
        chk("to_count", 32'(fifo_count), 32'd0);
        send_frame(8'h1C, 1'b0);
        exp_q.push_back(10'h01C);
        drain("to");

        // Short clock glitch inside a frame is filtered out
        p0 = perr_seen;
        f0 = ferr_seen;
        send_bits(mk_frame(8'h1C, 1'b0), 11, 4);
        wait_cyc(8);
        exp_q.push_back(10'h01C);
        chk("gl_perr", 32'(perr_seen - p0), 32'd0);
        chk("gl_ferr", 32'(ferr_seen - f0), 32'd0);
        drain("gl");

        // Reset in the middle of a frame with a word queued and overflow set
        for (int i = 0; i < 17; i++) send_frame(8'h2A, 1'b0);
        chk("mr_pre_ovf", 32'(overflow), 32'd1);
        send_bits(mk_frame(8'h33, 1'b0), 5, -1);
        RESET_N = 1'b0;
        #1;
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_data", 32'(out_data), 32'd0);
        chk("mr_count", 32'(fifo_count), 32'd0);
        chk("mr_perr", 32'(parity_err), 32'd0);
        chk("mr_ferr", 32'(frame_err), 32'd0);
        chk("mr_ovf", 32'(overflow), 32'd0);
        exp_q.delete();
        wait_cyc(4);
        RESET_N = 1'b1;
        wait_cyc(4);
        send_frame(8'h1C, 1'b0);
        exp_q.push_back(10'h01C);
        drain("mr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ps2_scan_rx.md
PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter FILTER_LEN, default 8, number of consecutive equal samples needed to accept a PS2_CLK level change.
REQ-003 SHALL have parameter TIMEOUT_US, default 2000, maximum time allowed between PS2_CLK falling edges inside a frame.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, output FIFO entries; must be a power of two, at least 2.
REQ-005 SHALL have parameter RAW_MODE, default 0; 1 means raw bytes, 0 means decoded key events.
REQ-006 SHALL have port CLOCK_50, input, 1 bit, the only clock; all logic is on its rising edge.
REQ-007 SHALL have port RESET_N, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port PS2_CLK, input, 1 bit, asynchronous keyboard clock.
REQ-009 SHALL have port PS2_DAT, input, 1 bit, asynchronous keyboard data.
REQ-010 SHALL have port out_data, output, 10 bits: {ext, brk, code[7:0]}.
REQ-011 SHALL have port out_valid, output, 1 bit, FIFO not empty.
REQ-012 SHALL have port out_ready, input, 1 bit, consumer accepts the head entry.
REQ-013 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits, current number of entries.
REQ-014 SHALL have port parity_err, output, 1 bit, one-cycle pulse on a parity failure.
REQ-015 SHALL have port frame_err, output, 1 bit, one-cycle pulse on a bad stop bit or a timeout.
REQ-016 SHALL have port overflow, output, 1 bit, sticky flag set when a word is dropped.
REQ-017 SHALL have port clear_ovf, input, 1 bit, clears overflow.

Function
REQ-018 SHALL pass PS2_CLK and PS2_DAT each through a two-flop synchronizer.
REQ-019 SHALL change the filtered clock level only after FILTER_LEN consecutive equal synchronized samples.
REQ-020 SHALL generate a one-cycle strobe on each 1->0 transition of the filtered clock, and sample the synchronized PS2_DAT on that strobe.
REQ-021 SHALL implement the FSM states IDLE, DATA, PARITY and STOP.
REQ-022 In IDLE, a strobe with DAT=0 SHALL go to DATA with the bit count at 0; a strobe with DAT=1 SHALL be ignored.
REQ-023 In DATA, each strobe SHALL shift in one bit, LSB first; after 8 bits the FSM SHALL go to PARITY.
REQ-024 In PARITY, the FSM SHALL record odd-parity validity over the 8 data bits plus the parity bit, then go to STOP.
REQ-025 In STOP, DAT=1 with good parity SHALL accept the byte; DAT=0 SHALL pulse frame_err; bad parity SHALL pulse parity_err (both may pulse together); the FSM SHALL then return to IDLE.
REQ-026 Outside IDLE, if no strobe arrives for CLK_HZ/1_000_000*TIMEOUT_US cycles, the FSM SHALL return to IDLE and pulse frame_err; the counter SHALL reload on every strobe.
REQ-027 With RAW_MODE=1, each accepted byte SHALL be pushed as {2'b00, byte}.
REQ-028 With RAW_MODE=0, byte 8'hE0 SHALL set the ext flag and 8'hF0 SHALL set the brk flag, and neither SHALL be pushed; any other byte SHALL push {ext, brk, byte} and clear both flags.
REQ-029 Any parity_err or frame_err SHALL clear the ext and brk flags.
REQ-030 The push SHALL occur on the cycle after the STOP strobe, and out_valid SHALL rise on the cycle after that push.
REQ-031 out_data SHALL always present the head entry (show-ahead); a pop SHALL occur when out_valid and out_ready are both 1.
REQ-032 A push SHALL be accepted if the FIFO is not full, or if a pop occurs in the same cycle; otherwise the word SHALL be dropped and overflow set.
REQ-033 On a simultaneous push and pop, fifo_count SHALL be unchanged and ordering SHALL be preserved.
REQ-034 If overflow set and clear_ovf occur in the same cycle, the set SHALL win.
REQ-035 Read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-036 On RESET_N=0, all outputs SHALL go to 0 immediately: out_valid, out_data, fifo_count, parity_err, frame_err and overflow.
REQ-037 Reset SHALL put the FSM in IDLE, clear the ext and brk flags, set the filtered clock and synchronizers to 1, and clear the pointers; a frame in progress SHALL be discarded.

Structure
REQ-038 Package ps2_pkg SHALL hold the FSM state enum, the constants PREFIX_EXT=8'hE0 and PREFIX_BRK=8'hF0, and the out_data field positions.
REQ-039 The FIFO SHALL be a separate sub-module named ps2_fifo, parameterised by width and depth; everything else SHALL stay in ps2_scan_rx.

Verification
REQ-040 Frame 0x1C (parity 0, stop 1) with RAW_MODE=0 -> out_data=10'h01C, fifo_count=1, no error pulses.
REQ-041 Frames E0, F0, 75 -> a single entry 10'h375.
REQ-042 Frame 0x1C with parity 1 -> exactly one parity_err pulse, no push; following frame 0x75 -> 10'h075.
REQ-043 17 frames with out_ready=0 and FIFO_DEPTH=16 -> fifo_count=16, overflow=1, first 16 codes read back in order; clear_ovf -> overflow=0.
REQ-044 Frame abandoned after 5 data bits, then 2.1 ms idle -> one frame_err pulse; next frame 0x1C decodes correctly.
REQ-045 A 3-cycle low glitch on PS2_CLK -> no strobe, no state change; RESET_N pulsed mid-frame -> all outputs 0, and the next full frame decodes correctly.
